// File: rtl/xor_parity_pkg.sv
// rtl/xor_parity_pkg.sv - shared types, defaults and parity helper for the XOR parity link
package xor_parity_pkg;

  // Receiver frame-tracking states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int DATA_W_DEF      = 8;
  localparam bit PARITY_EVEN     = 1'b0;
  localparam bit PARITY_ODD_MODE = 1'b1;

  // Parity bit a generator appends to a word (zero-extended to 32 bits)
  function automatic logic par_calc(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/xor_parity_rx_if.sv
// rtl/xor_parity_rx_if.sv - serial-in / word-out bundle for the XOR parity receiver
import xor_parity_pkg::*;

interface xor_parity_rx_if #(
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              in_valid;
  logic              in_bit;
  logic              in_sof;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_par_err;
  logic              frame_abort;
  logic              busy;

  // Link side: drives the serial stream, observes the results
  modport master (
    output in_valid, in_bit, in_sof,
    input  out_valid, out_data, out_par_err, frame_abort, busy
  );

  // Receiver side
  modport slave (
    input  in_valid, in_bit, in_sof,
    output out_valid, out_data, out_par_err, frame_abort, busy
  );
endinterface

// File: rtl/xor_parity_acc.sv
// rtl/xor_parity_acc.sv - 1-bit XOR accumulator with load/clear/enable
import xor_parity_pkg::*;

module xor_parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_en,
  input  logic i_bit,
  output logic o_acc
);

  logic r_acc;

  // Load starts a new running XOR and wins over clear/accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= 1'b0;
    end else if (i_load) begin
      r_acc <= i_bit;
    end else if (i_clr) begin
      r_acc <= 1'b0;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_bit;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/xor_parity_rx.sv
// rtl/xor_parity_rx.sv - XOR parity frame receiver; XOR_PARITY_RX_ERR_CNT_EN adds err_cnt
import xor_parity_pkg::*;

module xor_parity_rx #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit PARITY_ODD = PARITY_EVEN
) (
  input  logic            clk,
  input  logic            rst_n,
  xor_parity_rx_if.slave  bus
`ifdef XOR_PARITY_RX_ERR_CNT_EN
  ,
  output logic [7:0]      err_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_par_err;
  logic              r_frame_abort;

  logic w_sof;
  logic w_step;
  logic w_done;
  logic w_acc_en;
  logic w_acc;
  logic w_par_err;

  // sof always restarts a frame; a plain valid bit advances the current one
  assign w_sof     = bus.in_valid & bus.in_sof;
  assign w_step    = bus.in_valid & ~bus.in_sof;
  assign w_done    = w_step & (r_state == PARITY);
  assign w_acc_en  = w_step & (r_state == DATA);
  assign w_par_err = w_acc ^ bus.in_bit ^ PARITY_ODD;

  xor_parity_acc u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_done),
    .i_load (w_sof),
    .i_en   (w_acc_en),
    .i_bit  (bus.in_bit),
    .o_acc  (w_acc)
  );

  // Frame FSM with shifter; result and abort pulses are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_par_err <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_out_valid   <= 1'b0;
      r_frame_abort <= 1'b0;
      if (w_sof) begin
        // A new sof mid-frame throws away the partial word
        if (r_state != IDLE) begin
          r_frame_abort <= 1'b1;
        end
        r_shift <= DATA_W'(bus.in_bit);
        r_cnt   <= CNT_W'(1);
        r_state <= DATA;
      end else if (bus.in_valid) begin
        case (r_state)
          IDLE: begin
          end
          DATA: begin
            r_shift <= r_shift | (DATA_W'(bus.in_bit) << r_cnt);
            r_cnt   <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_IDX) begin
              r_state <= PARITY;
            end
          end
          PARITY: begin
            r_out_data    <= r_shift;
            r_out_par_err <= w_par_err;
            r_out_valid   <= 1'b1;
            r_cnt         <= '0;
            r_state       <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_par_err = r_out_par_err;
  assign bus.frame_abort = r_frame_abort;
  assign bus.busy        = (r_state != IDLE);

`ifdef XOR_PARITY_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of completed frames that failed the parity check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_done && w_par_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_xor_parity_rx.sv
// tb/tb_xor_parity_rx.sv - bench for xor_parity_rx (even and odd instances side by side)
import xor_parity_pkg::*;

module tb_xor_parity_rx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  xor_parity_rx_if #(.DATA_W(8)) if_e ();
  xor_parity_rx_if #(.DATA_W(8)) if_o ();

`ifdef XOR_PARITY_RX_ERR_CNT_EN
  logic [7:0] err_cnt_e;
  logic [7:0] err_cnt_o;
`endif

  xor_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) u_even (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_e)
`ifdef XOR_PARITY_RX_ERR_CNT_EN
    ,
    .err_cnt (err_cnt_e)
`endif
  );

  xor_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) u_odd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_o)
`ifdef XOR_PARITY_RX_ERR_CNT_EN
    ,
    .err_cnt (err_cnt_o)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  int cyc_n = 0;
  int n_valid = 0;
  int n_abort = 0;
  int n_both = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;

  // Pulse monitor on the even instance, sampled mid-cycle
  always @(negedge clk) begin
    cyc_n = cyc_n + 1;
    if (if_e.out_valid === 1'b1) begin
      n_valid = n_valid + 1;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc_n;
    end
    if (if_e.frame_abort === 1'b1) n_abort = n_abort + 1;
    if (if_e.out_valid === 1'b1 && if_e.frame_abort === 1'b1) n_both = n_both + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: apply inputs, take the edge, settle just after it
  task automatic cyc(input logic v, input logic s, input logic b);
    if_e.in_valid = v; if_e.in_sof = s; if_e.in_bit = b;
    if_o.in_valid = v; if_o.in_sof = s; if_o.in_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input bit toggle,
                            input int gap, output bit busy_drop, output bit early_valid);
    busy_drop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, (i == 0), d[i]);
      if (if_e.busy !== 1'b1) busy_drop = 1'b1;
      if (toggle) begin
        cyc(1'b0, 1'b0, 1'b0);
        if (if_e.busy !== 1'b1) busy_drop = 1'b1;
      end
    end
    early_valid = if_e.out_valid;
    for (int g = 0; g < gap; g++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (if_e.busy !== 1'b1) busy_drop = 1'b1;
    end
    cyc(1'b1, 1'b0, p);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       exp_err;
  } vec_t;

  vec_t vecs [8];
  bit   bd;
  bit   ev;
  int   a0;
  int   v0;
  int   exp_errs;

  initial begin
    vecs[0] = '{data: 8'hA5, par: 1'b1, exp_err: 1'b1};
    vecs[1] = '{data: 8'h00, par: 1'b0, exp_err: 1'b0};
    vecs[2] = '{data: 8'hFF, par: 1'b0, exp_err: 1'b0};
    vecs[3] = '{data: 8'h07, par: 1'b1, exp_err: 1'b0};
    vecs[4] = '{data: 8'h07, par: 1'b0, exp_err: 1'b1};
    vecs[5] = '{data: 8'h80, par: 1'b0, exp_err: 1'b1};
    vecs[6] = '{data: 8'h5A, par: 1'b1, exp_err: 1'b1};
    vecs[7] = '{data: 8'h01, par: 1'b0, exp_err: 1'b1};
    exp_errs = 0;

    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("rst_valid", if_e.out_valid, 0);
    check("rst_data", if_e.out_data, 0);
    check("rst_err", if_e.out_par_err, 0);
    check("rst_abort", if_e.frame_abort, 0);
    check("rst_busy", if_e.busy, 0);
`ifdef XOR_PARITY_RX_ERR_CNT_EN
    check("rst_err_cnt", err_cnt_e, 0);
`endif
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // 0xA5 good even parity, continuous valid
    send_frame(8'hA5, 1'b0, 1'b0, 0, bd, ev);
    check("a5_no_early_valid", ev, 0);
    check("a5_valid", if_e.out_valid, 1);
    check("a5_data", if_e.out_data, 8'hA5);
    check("a5_err", if_e.out_par_err, 0);
    check("a5_odd_err", if_o.out_par_err, 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("a5_pulse_one_cycle", if_e.out_valid, 0);
    check("a5_data_held", if_e.out_data, 8'hA5);
    check("a5_busy_idle", if_e.busy, 0);

    // Table of frames
    for (int k = 0; k < 8; k++) begin
      send_frame(vecs[k].data, vecs[k].par, 1'b0, 0, bd, ev);
      check($sformatf("vec%0d_valid", k), if_e.out_valid, 1);
      check($sformatf("vec%0d_data", k), if_e.out_data, vecs[k].data);
      check($sformatf("vec%0d_err", k), if_e.out_par_err, vecs[k].exp_err);
      check($sformatf("vec%0d_odd_err", k), if_o.out_par_err, !vecs[k].exp_err);
`ifdef XOR_PARITY_RX_ERR_CNT_EN
      if (vecs[k].exp_err && exp_errs < 255) exp_errs++;
      check($sformatf("vec%0d_err_cnt", k), err_cnt_e, exp_errs);
`endif
      cyc(1'b0, 1'b0, 1'b0);
    end

    // 0x3C with valid toggling and a 5-cycle gap before parity
    send_frame(8'h3C, 1'b0, 1'b1, 5, bd, ev);
    check("3c_busy_held", bd, 0);
    check("3c_valid", if_e.out_valid, 1);
    check("3c_data", if_e.out_data, 8'h3C);
    check("3c_err", if_e.out_par_err, 0);
    check("3c_busy_after", if_e.busy, 0);
    cyc(1'b0, 1'b0, 1'b0);

    // Partial frame aborted by a new sof
    a0 = n_abort;
    v0 = n_valid;
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 0, bd, ev);
    check("abort_data", if_e.out_data, 8'hFF);
    check("abort_err", if_e.out_par_err, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("abort_pulses", n_abort - a0, 1);
    check("abort_valid_pulses", n_valid - v0, 1);

    // Back-to-back frames, second sof directly after first parity
    send_frame(8'h01, 1'b1, 1'b0, 0, bd, ev);
    check("b2b_first_data", if_e.out_data, 8'h01);
    check("b2b_first_err", if_e.out_par_err, 0);
    send_frame(8'h80, 1'b1, 1'b0, 0, bd, ev);
    check("b2b_second_valid", if_e.out_valid, 1);
    check("b2b_second_data", if_e.out_data, 8'h80);
    check("b2b_second_err", if_e.out_par_err, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 9);

    // Reset in the middle of a frame
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    check("mid_busy", if_e.busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", if_e.busy, 0);
    check("mid_rst_data", if_e.out_data, 0);
    check("mid_rst_err", if_e.out_par_err, 0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    a0 = n_abort;
    v0 = n_valid;
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("post_rst_no_valid", n_valid - v0, 0);
    check("post_rst_no_abort", n_abort - a0, 0);
    check("post_rst_busy", if_e.busy, 0);
`ifdef XOR_PARITY_RX_ERR_CNT_EN
    exp_errs = 0;
    check("post_rst_err_cnt", err_cnt_e, 0);
`endif
    send_frame(8'h00, 1'b0, 1'b0, 0, bd, ev);
    check("fresh_valid", if_e.out_valid, 1);
    check("fresh_data", if_e.out_data, 8'h00);
    check("fresh_err", if_e.out_par_err, 0);
    cyc(1'b0, 1'b0, 1'b0);

`ifdef XOR_PARITY_RX_ERR_CNT_EN
    for (int f = 0; f < 300; f++) begin
      send_frame(8'h00, 1'b1, 1'b0, 0, bd, ev);
    end
    cyc(1'b0, 1'b0, 1'b0);
    check("err_cnt_saturate", err_cnt_e, 8'd255);
`endif

    check("never_valid_and_abort", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
